// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: synchronous FIFO controller for fifo_mem with two
// round-robin arbitrated write requesters and a single reader.
// Optional build macro FIFO_WR_ARB_CTRL_ERR_EN adds sticky overflow and
// underflow error flags with a shared clear input.
module fifo_wr_arb_ctrl #(
    parameter int unsigned FIFO_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [FIFO_WIDTH-1:0] data0,
    input  logic [FIFO_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [FIFO_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
    ,
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  unf_err
`endif
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] count_nxt;
    logic             last;
    logic             wr_acc;
    logic             rd_acc;

    // Round-robin grant; no grant while full or while reset is asserted
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !full) begin
            if (req0 && req1) begin
                if (last) gnt0 = 1'b1;
                else      gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Memory port drive and next occupancy
    always_comb begin
        wr_acc      = gnt0 | gnt1;
        rd_acc      = rst_n & rd_req & ~empty;
        mem_wr_en   = wr_acc;
        mem_wr_data = gnt1 ? data1 : data0;
        mem_wr_addr = wptr[ADDR_WIDTH-1:0];
        mem_rd_en   = rd_acc;
        mem_rd_addr = rptr[ADDR_WIDTH-1:0];
        count_nxt   = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + PTR_W'(1);
            2'b01:   count_nxt = count - PTR_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy, flags, arbitration history and read-valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            last        <= 1'b1;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_W'(1);
            if (rd_acc) rptr <= rptr + PTR_W'(1);
            if (gnt0) last <= 1'b0;
            else if (gnt1) last <= 1'b1;
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == PTR_W'(FIFO_DEPTH));
            almost_full <= (count_nxt >= PTR_W'(AF_LEVEL));
            rd_valid    <= rd_acc;
        end
    end

`ifdef FIFO_WR_ARB_CTRL_ERR_EN
    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (err_clr) begin
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end
            if ((req0 | req1) & full) ovf_err <= 1'b1;
            if (rd_req & empty)       unf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Scoreboard bench for fifo_wr_arb_ctrl with a behavioural fifo_mem model.
module tb_fifo_wr_arb_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned A = 3;

    logic         clk;
    logic         rst_n;
    logic         req0, req1, rd_req;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, rd_valid;
    logic         mem_wr_en, mem_rd_en;
    logic [A-1:0] mem_wr_addr, mem_rd_addr;
    logic [W-1:0] mem_wr_data;
    logic         full, empty, almost_full;
    logic [A:0]   count;
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
    logic         err_clr, ovf_err, unf_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] vals[$];

    // fifo_mem model: both ports on clk, registered read data
    logic [W-1:0] mem [8];
    logic [W-1:0] rd_data;

    fifo_wr_arb_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .ADDR_WIDTH(A), .AF_LEVEL(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_valid(rd_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count)
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
        , .err_clr(err_clr), .ovf_err(ovf_err), .unf_err(unf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue n reads back to back, queueing the expected words
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) check("rd_valid_stream", rd_valid, 1);
            req0 = 1'b0; req1 = 1'b0; rd_req = 1'b1;
            #1 check("drain_rd_en", mem_rd_en, 1);
            sb.push_back(vals[i]);
        end
        @(negedge clk);
        check("rd_valid_last", rd_valid, 1);
        rd_req = 1'b0;
        @(negedge clk);
        check("rd_valid_idle", rd_valid, 0);
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1;
        data0 = '0; data1 = '0;
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
        // Read monitor: compares every rd_valid cycle against the scoreboard
        fork
            forever begin
                @(negedge clk);
                if (rst_n && rd_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_unexpected: got rd_valid=1 data=%0h expected none at %0t", rd_data, $time);
                    end else begin
                        check("rd_data", rd_data, sb.pop_front());
                    end
                end
            end
        join_none

        // Reset state, requests ignored while reset is low
        @(negedge clk); @(negedge clk); #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_count", count, 0);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_rd_valid", rd_valid, 0);

        // Both requesters held: grants alternate starting with requester 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = 1'b1; rd_req = 1'b0;
            req0 = 1'b1; req1 = 1'b1; data0 = 4'hA; data1 = 4'h5;
            #1;
            check("alt_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("alt_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
        end
        vals = {4'hA, 4'h5, 4'hA, 4'h5};
        drain(4);

        // Fill with requester 0 alone, then a ninth request is refused
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fill_count", count, i);
            check("fill_af", almost_full, (i >= 6) ? 1 : 0);
            check("fill_full", full, 0);
            req0 = 1'b1; data0 = W'(i + 1);
            #1 check("fill_gnt0", gnt0, 1);
        end
        @(negedge clk);
        check("full_count", count, 8);
        check("full_flag", full, 1);
        check("full_af", almost_full, 1);
        #1;
        check("ninth_gnt0", gnt0, 0);
        check("ninth_wr_en", mem_wr_en, 0);
        @(negedge clk);
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
        check("ovf_err_set", ovf_err, 1);
`endif
        req0 = 1'b0;
        vals = {};
        for (int i = 0; i < 8; i++) vals.push_back(W'(i + 1));
        drain(8);

        // Fill with requester 1, then read and write together at full
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req1 = 1'b1; data1 = W'(i);
            #1 check("fill1_gnt1", gnt1, 1);
        end
        @(negedge clk);
        check("full1_flag", full, 1);
        rd_req = 1'b1; req1 = 1'b1; data1 = 4'h9;
        #1;
        check("fullrw_gnt1", gnt1, 0);
        check("fullrw_rd_en", mem_rd_en, 1);
        sb.push_back(4'h0);
        @(negedge clk);
        check("fullrw_count", count, 7);
        check("fullrw_full", full, 0);
        check("fullrw_rd_valid", rd_valid, 1);
        rd_req = 1'b0;
        #1 check("space_gnt1", gnt1, 1);
        @(negedge clk);
        check("refill_count", count, 8);
        check("refill_full", full, 1);
        vals = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};
        drain(8);

        // Streaming write+read each cycle, pointers wrap, order preserved
        @(negedge clk);
        req0 = 1'b1; data0 = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stream_count", count, 1);
            req0 = 1'b1; data0 = W'(i + 1); rd_req = 1'b1;
            #1;
            check("stream_gnt0", gnt0, 1);
            check("stream_rd_en", mem_rd_en, 1);
            sb.push_back(W'(i));
        end
        @(negedge clk);
        check("stream_end_count", count, 1);
        req0 = 1'b0; rd_req = 1'b1;
        sb.push_back(4'h4);
        @(negedge clk);
        rd_req = 1'b0;
        check("stream_drained", count, 0);
        check("stream_empty", empty, 1);

        // Read at empty is ignored
        @(negedge clk);
        rd_req = 1'b1;
        #1 check("empty_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rd_req = 1'b0;
        check("empty_rd_valid", rd_valid, 0);
`ifdef FIFO_WR_ARB_CTRL_ERR_EN
        check("unf_err_set", unf_err, 1);
        check("ovf_err_sticky", ovf_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovf_err_clr", ovf_err, 0);
        check("unf_err_clr", unf_err, 0);
`endif

        // Asynchronous reset mid-stream with five words stored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0 = 1'b1; data0 = W'(i + 3);
        end
        @(negedge clk);
        req0 = 1'b0;
        check("pre_rst_count", count, 5);
        #2 rst_n = 1'b0; req0 = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_af", almost_full, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_gnt0", gnt0, 0);
        @(negedge clk);
        rst_n = 1'b1; req0 = 1'b0; rd_req = 1'b1;
        #1 check("post_rst_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rd_req = 1'b0;
        check("post_rst_rd_valid", rd_valid, 0);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
